// File: rtl/demux_arb_pkg.sv
// Shared definitions for the round-robin arbiter feeding the DeMux2x1 datapath:
// FSM state encodings and default datapath geometry.
package demux_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_RESET  = 2'd0;
  localparam arb_state_t ST_IDLE   = 2'd1;
  localparam arb_state_t ST_ACTIVE = 2'd2;
  localparam arb_state_t ST_PAUSE  = 2'd3;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_SEL_BIT    = 7;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant: when both sources request, the one not served
// last wins; a lone requester always wins. Purely combinational.
module rr_grant2
  import demux_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  // Pick the granted index from the request pattern and the last winner
  always_comb begin
    grant_valid_o = |req_i;
    case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      default: grant_o = ~last_grant_i;
    endcase
  end

endmodule

// File: rtl/demux_rr_arbiter.sv
// Drains two upstream FIFOs in round-robin order into the shared demux,
// registering each returned word with a valid strobe and a selector taken
// from the word's routing bit. All pops stop while either downstream FIFO
// is almost full; words already popped are still delivered.
module demux_rr_arbiter
  import demux_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SEL_BIT    = DEFAULT_SEL_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty0,
  input  logic                  fifo_empty1,
  input  logic [DATA_WIDTH-1:0] fifo_data0,
  input  logic [DATA_WIDTH-1:0] fifo_data1,
  input  logic                  almost_full0,
  input  logic                  almost_full1,
  output logic                  pop0,
  output logic                  pop1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  demux_sel,
  output logic [1:0]            state,
  output logic                  idle
);

  arb_state_t            state_q, state_d;
  logic                  last_grant_q;
  logic                  pop_pend_q;
  logic                  pop_src_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  sel_q;

  logic [1:0]            req;
  logic                  grant;
  logic                  grant_valid;
  logic                  stall;
  logic                  pop_any;
  logic [DATA_WIDTH-1:0] returned_word;

  assign req   = {~fifo_empty1, ~fifo_empty0};
  assign stall = almost_full0 | almost_full1;

  rr_grant2 u_grant (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_valid_o(grant_valid)
  );

  // A pop is only ever issued to a non-empty FIFO, never under backpressure,
  // and is dropped immediately while reset is held so no word is lost upstream
  assign pop_any = reset & (state_q == ST_ACTIVE) & grant_valid & ~stall;
  assign pop0    = pop_any & ~grant;
  assign pop1    = pop_any & grant;

  // The FIFO answers one cycle after the pop; pick the source that was popped
  assign returned_word = pop_src_q ? fifo_data1 : fifo_data0;

  // Next-state decisions: backpressure dominates, then FIFO occupancy
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_IDLE;
      ST_IDLE: begin
        if (stall)            state_d = ST_PAUSE;
        else if (grant_valid) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (stall)             state_d = ST_PAUSE;
        else if (!grant_valid) state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        if (!stall) state_d = grant_valid ? ST_ACTIVE : ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  // State, grant history and the two-stage pop-to-output pipeline
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RESET;
      last_grant_q <= 1'b1;
      pop_pend_q   <= 1'b0;
      pop_src_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sel_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop_pend_q <= pop_any;
      pop_src_q  <= grant;
      valid_q    <= pop_pend_q;
      if (pop_any) begin
        last_grant_q <= grant;
      end
      if (pop_pend_q) begin
        data_q <= returned_word;
        sel_q  <= returned_word[SEL_BIT];
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign demux_sel = sel_q;
  assign state     = state_q;
  assign idle      = (state_q == ST_IDLE) & ~pop_pend_q;

endmodule

// File: tb/tb_demux_rr_arbiter.sv
// Bench for demux_rr_arbiter: emulates the two upstream FIFOs with queues,
// drives random traffic/backpressure/reset, and compares every cycle against
// a reference model built from the arbitration rules.
`timescale 1ns/1ps
module tb_demux_rr_arbiter;

  localparam int DW = 8;
  localparam int SB = 7;
  localparam int M_RESET  = 0;
  localparam int M_IDLE   = 1;
  localparam int M_ACTIVE = 2;
  localparam int M_PAUSE  = 3;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } flight_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty0, fifo_empty1;
  logic [DW-1:0] fifo_data0, fifo_data1;
  logic          almost_full0, almost_full1;
  logic          pop0, pop1;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          demux_sel;
  logic [1:0]    state;
  logic          idle;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  flight_t       inflight[$];
  int            cyc;
  int            mMode;
  int            mLast;
  logic          mValid;
  logic [DW-1:0] mData;
  int            testsRun;
  int            testsFailed;

  demux_rr_arbiter #(.DATA_WIDTH(DW), .SEL_BIT(SB)) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty0 (fifo_empty0),
    .fifo_empty1 (fifo_empty1),
    .fifo_data0  (fifo_data0),
    .fifo_data1  (fifo_data1),
    .almost_full0(almost_full0),
    .almost_full1(almost_full1),
    .pop0        (pop0),
    .pop1        (pop1),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .demux_sel   (demux_sel),
    .state       (state),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic drawControls(input int af0Pct, input int af1Pct, input int rstPct);
    almost_full0 = (int'($urandom_range(0, 99)) < af0Pct);
    almost_full1 = (int'($urandom_range(0, 99)) < af1Pct);
    reset        = !(int'($urandom_range(0, 99)) < rstPct);
  endtask

  task automatic loadWord(input int src, input logic [DW-1:0] d);
    if (src == 0) q0.push_back(d);
    else          q1.push_back(d);
    fifo_empty0 = (q0.size() == 0);
    fifo_empty1 = (q1.size() == 0);
  endtask

  task automatic applyStimulus(input int n, input int p0, input int p1,
                               input int af0Pct, input int af1Pct, input int rstPct);
    logic          a0, a1, stall, anyNe, expIdle;
    int            src, hit;
    logic [DW-1:0] w;
    drawControls(af0Pct, af1Pct, rstPct);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      stall = almost_full0 | almost_full1;
      anyNe = (q0.size() > 0) || (q1.size() > 0);
      src = -1;
      if (reset && mMode == M_ACTIVE && !stall) begin
        if (q0.size() > 0 && q1.size() > 0) src = 1 - mLast;
        else if (q0.size() > 0)             src = 0;
        else if (q1.size() > 0)             src = 1;
      end
      expIdle = (mMode == M_IDLE);
      foreach (inflight[i]) if (inflight[i].due == cyc + 1) expIdle = 1'b0;

      checkOutput("pop0", pop0, src == 0);
      checkOutput("pop1", pop1, src == 1);
      checkOutput("popExclusive", pop0 & pop1, 0);
      checkOutput("valid_out", valid_out, mValid);
      checkOutput("data_out", data_out, mData);
      checkOutput("demux_sel", demux_sel, mData[SB]);
      checkOutput("state", state, mMode);
      checkOutput("idle", idle, expIdle);

      if (!reset) begin
        mMode  = M_RESET;
        mLast  = 1;
        mValid = 1'b0;
        mData  = '0;
        inflight.delete();
      end else begin
        mValid = 1'b0;
        hit = -1;
        foreach (inflight[i]) if (hit < 0 && inflight[i].due == cyc + 1) hit = i;
        if (hit >= 0) begin
          mValid = 1'b1;
          mData  = inflight[hit].data;
          inflight.delete(hit);
        end
        if (src >= 0) begin
          w = (src == 0) ? q0[0] : q1[0];
          inflight.push_back('{data: w, due: cyc + 2});
          mLast = src;
        end
        case (mMode)
          M_RESET:  mMode = M_IDLE;
          M_IDLE:   if (stall) mMode = M_PAUSE; else if (anyNe) mMode = M_ACTIVE;
          M_ACTIVE: if (stall) mMode = M_PAUSE; else if (!anyNe) mMode = M_IDLE;
          M_PAUSE:  if (!stall) mMode = anyNe ? M_ACTIVE : M_IDLE;
          default:  mMode = M_RESET;
        endcase
      end

      a0 = pop0;
      a1 = pop1;
      @(posedge clk);
      #1;
      if (a0 && q0.size() > 0) fifo_data0 = q0.pop_front();
      if (a1 && q1.size() > 0) fifo_data1 = q1.pop_front();
      if (int'($urandom_range(0, 99)) < p0 && q0.size() < 16) q0.push_back(DW'($urandom));
      if (int'($urandom_range(0, 99)) < p1 && q1.size() < 16) q1.push_back(DW'($urandom));
      fifo_empty0 = (q0.size() == 0);
      fifo_empty1 = (q1.size() == 0);
      drawControls(af0Pct, af1Pct, rstPct);
      cyc++;
    end
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    cyc          = 0;
    reset        = 1'b0;
    fifo_empty0  = 1'b1;
    fifo_empty1  = 1'b1;
    fifo_data0   = '0;
    fifo_data1   = '0;
    almost_full0 = 1'b0;
    almost_full1 = 1'b0;
    mMode        = M_RESET;
    mLast        = 1;
    mValid       = 1'b0;
    mData        = '0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset held, then released with both FIFOs empty");
    applyStimulus(3, 0, 0, 0, 0, 100);
    applyStimulus(5, 0, 0, 0, 0, 0);

    $display("[TB] single source from FIFO0");
    loadWord(0, 8'h11);
    loadWord(0, 8'h92);
    loadWord(0, 8'h23);
    applyStimulus(8, 0, 0, 0, 0, 0);

    $display("[TB] dual source, four words each");
    for (int i = 0; i < 4; i++) begin
      loadWord(0, DW'($urandom));
      loadWord(1, DW'($urandom));
    end
    applyStimulus(14, 0, 0, 0, 0, 0);

    $display("[TB] backpressure on downstream FIFO1 mid-stream");
    for (int i = 0; i < 6; i++) begin
      loadWord(0, DW'($urandom));
      loadWord(1, DW'($urandom));
    end
    applyStimulus(4, 0, 0, 0, 0, 0);
    applyStimulus(4, 0, 0, 0, 100, 0);
    applyStimulus(14, 0, 0, 0, 0, 0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 4; i++) begin
      loadWord(0, DW'($urandom));
      loadWord(1, DW'($urandom));
    end
    applyStimulus(4, 0, 0, 0, 0, 0);
    applyStimulus(2, 0, 0, 0, 0, 100);
    applyStimulus(14, 0, 0, 0, 0, 0);

    $display("[TB] granted FIFO running empty");
    loadWord(0, 8'h81);
    loadWord(1, 8'h02);
    loadWord(1, 8'h83);
    loadWord(1, 8'h04);
    applyStimulus(10, 0, 0, 0, 0, 0);

    $display("[TB] random traffic");
    applyStimulus(300, 45, 45, 6, 6, 1);
    applyStimulus(300, 80, 20, 3, 10, 1);
    applyStimulus(40, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
